coin_start_seq: RTL and testbench

- Sequences the cabinet coin and start inputs of the Lady Bug core from the player's start requests (keyboard F1/F2, joystick start buttons).
- Replaces the direct OR of start into coin with a timed, frame-based sequence: coin pulse(s), gap, then start pulse.
- Sits between the input decode logic and the core's but_coin_s / but_select_s inputs; the top level inverts the outputs there.
- Arbitrates between the two start requesters so only one sequence runs at a time.

---
 rtl/ladybug_pkg.sv | 37 +++
 rtl/coin_start_seq_if.sv | 31 +++
 rtl/vblank_tick.sv | 25 ++
 rtl/coin_start_seq.sv | 153 +++++++++++++++
 tb/tb_coin_start_seq.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybug_pkg.sv
// Shared Lady Bug core types: start-sequencer states, player select and output bundle.
// The decode function is the single source of truth for what each state drives.
package ladybug_pkg;

    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        RELEASE
    } seq_state_t;

    typedef enum logic {
        P1,
        P2
    } player_t;

    typedef struct packed {
        logic busy;
        logic coin;
        logic start1;
        logic start2;
    } seq_out_t;

    function automatic seq_out_t seq_decode(seq_state_t st, player_t sel);
        seq_out_t o;
        o        = '0;
        o.busy   = (st != IDLE);
        o.coin   = (st == COIN);
        o.start1 = (st == START) && (sel == P1);
        o.start2 = (st == START) && (sel == P2);
        return o;
    endfunction

endpackage

// File: rtl/coin_start_seq_if.sv
// Cabinet-side signals of the coin/start sequencer: frame timing and requests in, pulses out.
// master drives requests and vblank; slave is the sequencer.
interface coin_start_seq_if;
    logic vblank;
    logic req_start1;
    logic req_start2;
    logic coin_out;
    logic start1_out;
    logic start2_out;
    logic busy;

    modport master (
        output vblank,
        output req_start1,
        output req_start2,
        input  coin_out,
        input  start1_out,
        input  start2_out,
        input  busy
    );

    modport slave (
        input  vblank,
        input  req_start1,
        input  req_start2,
        output coin_out,
        output start1_out,
        output start2_out,
        output busy
    );
endinterface

// File: rtl/vblank_tick.sv
// One-cycle frame tick on the cycle after vblank is first seen high; one cycle latency
// from the sampling edge, no backpressure (free-running pulse).
module vblank_tick (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_vblank,
    output logic o_tick
);

    logic r_vblank_q;
    logic r_tick;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_vblank_q <= i_vblank;
            r_tick     <= i_vblank & ~r_vblank_q;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/coin_start_seq.sv
// Turns player start requests into a frame-timed coin / gap / start sequence for the core.
// Request edge to coin_out is two cycles; requests arriving while busy are dropped, not queued.
module coin_start_seq
    import ladybug_pkg::*;
#(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    coin_start_seq_if.slave sif
);

    if (COIN_FRAMES < 1 || COIN_FRAMES > 255) begin : g_bad_coin
        $error("COIN_FRAMES must be in 1..255");
    end
    if (GAP_FRAMES < 1 || GAP_FRAMES > 255) begin : g_bad_gap
        $error("GAP_FRAMES must be in 1..255");
    end
    if (START_FRAMES < 1 || START_FRAMES > 255) begin : g_bad_start
        $error("START_FRAMES must be in 1..255");
    end

    localparam logic [FRAME_CNT_W-1:0] COIN_LAST  = FRAME_CNT_W'(COIN_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] GAP_LAST   = FRAME_CNT_W'(GAP_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] START_LAST = FRAME_CNT_W'(START_FRAMES - 1);

    logic w_tick;

    vblank_tick u_vblank_tick (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .i_vblank (sif.vblank),
        .o_tick   (w_tick)
    );

    // r_armed keeps a request held across reset release from looking like a fresh press.
    logic r_armed;
    logic r_req1_q;
    logic r_req2_q;
    logic r_edge1;
    logic r_edge2;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_armed  <= 1'b0;
            r_req1_q <= 1'b0;
            r_req2_q <= 1'b0;
            r_edge1  <= 1'b0;
            r_edge2  <= 1'b0;
        end else begin
            r_armed  <= 1'b1;
            r_req1_q <= sif.req_start1;
            r_req2_q <= sif.req_start2;
            r_edge1  <= r_armed & sif.req_start1 & ~r_req1_q;
            r_edge2  <= r_armed & sif.req_start2 & ~r_req2_q;
        end
    end

    seq_state_t             r_state;
    player_t                r_sel;
    logic [1:0]             r_coins_left;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    seq_out_t               r_out;

    logic w_coin_done;
    logic w_gap_done;
    logic w_start_done;

    assign w_coin_done  = w_tick && (r_frame_cnt == COIN_LAST);
    assign w_gap_done   = w_tick && (r_frame_cnt == GAP_LAST);
    assign w_start_done = w_tick && (r_frame_cnt == START_LAST);

    // Outputs are loaded with the decode of the state being entered, so they
    // move on the same edge as r_state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sel        <= P1;
            r_coins_left <= '0;
            r_frame_cnt  <= '0;
            r_out        <= '0;
        end else begin
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_edge1) begin
                        r_state      <= COIN;
                        r_sel        <= P1;
                        r_coins_left <= 2'd1;
                        r_frame_cnt  <= '0;
                        r_out        <= seq_decode(COIN, P1);
                    end else if (r_edge2) begin
                        r_state      <= COIN;
                        r_sel        <= P2;
                        r_coins_left <= 2'd2;
                        r_frame_cnt  <= '0;
                        r_out        <= seq_decode(COIN, P2);
                    end
                end
                COIN: begin
                    if (w_coin_done) begin
                        r_state      <= GAP;
                        r_coins_left <= r_coins_left - 2'd1;
                        r_frame_cnt  <= '0;
                        r_out        <= seq_decode(GAP, r_sel);
                    end
                end
                GAP: begin
                    if (w_gap_done) begin
                        r_frame_cnt <= '0;
                        if (r_coins_left != 2'd0) begin
                            r_state <= COIN;
                            r_out   <= seq_decode(COIN, r_sel);
                        end else begin
                            r_state <= START;
                            r_out   <= seq_decode(START, r_sel);
                        end
                    end
                end
                START: begin
                    if (w_start_done) begin
                        r_state     <= RELEASE;
                        r_frame_cnt <= '0;
                        r_out       <= seq_decode(RELEASE, r_sel);
                    end
                end
                RELEASE: begin
                    // Waiting for both buttons up stops a held button from re-triggering.
                    if (!sif.req_start1 && !sif.req_start2) begin
                        r_state     <= IDLE;
                        r_frame_cnt <= '0;
                        r_out       <= seq_decode(IDLE, r_sel);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_frame_cnt <= '0;
                    r_out       <= '0;
                end
            endcase
        end
    end

    assign sif.coin_out   = r_out.coin;
    assign sif.start1_out = r_out.start1;
    assign sif.start2_out = r_out.start2;
    assign sif.busy       = r_out.busy;

endmodule

// File: tb/tb_coin_start_seq.sv
// Scoreboard bench: expected output segments {busy,coin,start1,start2 ; frame ticks} are queued
// when a request is driven and compared as the monitor sees each segment end.
module tb_coin_start_seq;

    logic clk_sys = 1'b0;
    logic reset_n;

    always #5 clk_sys = ~clk_sys;

    coin_start_seq_if sif ();
    coin_start_seq_if sif2 ();

    coin_start_seq #(
        .COIN_FRAMES  (4),
        .GAP_FRAMES   (8),
        .START_FRAMES (4)
    ) u_dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .sif     (sif)
    );

    coin_start_seq #(
        .COIN_FRAMES  (1),
        .GAP_FRAMES   (1),
        .START_FRAMES (1)
    ) u_dut_min (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .sif     (sif2)
    );

    typedef struct {
        logic [3:0] pat;
        int         len;
    } seg_t;

    seg_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_sel = 0;

    logic [3:0] cur_pat = 4'b0000;
    int         cur_ticks = 0;
    logic       vb_d1 = 1'b0;
    logic       vb_d2 = 1'b0;
    logic [3:0] m_pat;
    logic       m_tick;
    seg_t       m_exp;

    // vblank: 64-cycle frame, high for 4 cycles, shared by both DUTs
    initial begin
        sif.vblank  = 1'b0;
        sif2.vblank = 1'b0;
        forever begin
            repeat (60) @(posedge clk_sys);
            #1;
            sif.vblank  = 1'b1;
            sif2.vblank = 1'b1;
            repeat (4) @(posedge clk_sys);
            #1;
            sif.vblank  = 1'b0;
            sif2.vblank = 1'b0;
        end
    end

    // A vblank rise seen two negedges back is the tick the DUT consumes at the next posedge.
    initial begin
        forever begin
            @(negedge clk_sys);
            m_pat = (mon_sel != 0) ?
                {sif2.busy, sif2.coin_out, sif2.start1_out, sif2.start2_out} :
                {sif.busy,  sif.coin_out,  sif.start1_out,  sif.start2_out};
            m_tick = vb_d1 && !vb_d2;
            vb_d2  = vb_d1;
            vb_d1  = sif.vblank;
            if (m_pat !== cur_pat) begin
                if (cur_pat != 4'b0000) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL seg_unexpected: got pat=%b ticks=%0d, expected no segment",
                                 cur_pat, cur_ticks);
                    end else begin
                        m_exp = sb.pop_front();
                        if (cur_pat !== m_exp.pat || (m_exp.len >= 0 && cur_ticks != m_exp.len)) begin
                            errors++;
                            $display("FAIL segment: got pat=%b ticks=%0d, expected pat=%b ticks=%0d",
                                     cur_pat, cur_ticks, m_exp.pat, m_exp.len);
                        end
                    end
                end
                cur_pat   = m_pat;
                cur_ticks = 0;
            end
            if (m_tick) cur_ticks++;
        end
    end

    task automatic push_seq(input int coins, input bit p2, input int cf, input int gf, input int sf);
        seg_t s;
        for (int i = 0; i < coins; i++) begin
            s.pat = 4'b1100; s.len = cf; sb.push_back(s);
            s.pat = 4'b1000; s.len = gf; sb.push_back(s);
        end
        s.pat = p2 ? 4'b1001 : 4'b1010; s.len = sf; sb.push_back(s);
        s.pat = 4'b1000; s.len = -1; sb.push_back(s);
    endtask

    task automatic wait_done(input int budget, input string name);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk_sys);
            #1;
            n++;
            if (sb.size() == 0 && cur_pat == 4'b0000) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: %0d segments still pending after %0d cycles, expected 0",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        sif.req_start1  = 1'b0;
        sif.req_start2  = 1'b0;
        sif2.req_start1 = 1'b0;
        sif2.req_start2 = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if (sif.coin_out !== 1'b0) begin errors++; $display("FAIL rst_coin: got %b expected 0", sif.coin_out); end
        checks++;
        if (sif.start1_out !== 1'b0) begin errors++; $display("FAIL rst_start1: got %b expected 0", sif.start1_out); end
        checks++;
        if (sif.start2_out !== 1'b0) begin errors++; $display("FAIL rst_start2: got %b expected 0", sif.start2_out); end
        checks++;
        if (sif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", sif.busy); end
        checks++;
        if (sif2.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_min: got %b expected 0", sif2.busy); end
        @(posedge clk_sys);
        #2 reset_n = 1'b1;
        repeat (4) @(posedge clk_sys);
    endtask

    task automatic test_p1();
        push_seq(1, 1'b0, 4, 8, 4);
        @(posedge clk_sys);
        #1 sif.req_start1 = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (sif.coin_out !== 1'b0) begin errors++; $display("FAIL p1_lat_early: coin got %b expected 0", sif.coin_out); end
        @(negedge clk_sys);
        checks++;
        if (sif.coin_out !== 1'b1) begin errors++; $display("FAIL p1_lat_rise: coin got %b expected 1", sif.coin_out); end
        @(posedge clk_sys);
        #1 sif.req_start1 = 1'b0;
        wait_done(2000, "p1");
    endtask

    task automatic test_p2_two_coins();
        push_seq(2, 1'b1, 4, 8, 4);
        @(posedge clk_sys);
        #1 sif.req_start2 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 sif.req_start2 = 1'b0;
        wait_done(3000, "p2");
    endtask

    task automatic test_simultaneous();
        int  n;
        bit  seen;
        bit  fell;
        push_seq(1, 1'b0, 4, 8, 4);
        @(posedge clk_sys);
        #1;
        sif.req_start1 = 1'b1;
        sif.req_start2 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        sif.req_start1 = 1'b0;
        sif.req_start2 = 1'b0;
        n = 0; seen = 1'b0; fell = 1'b0;
        while (n < 1000 && !fell) begin
            @(negedge clk_sys);
            n++;
            if (sif.coin_out === 1'b1) seen = 1'b1;
            else if (seen) fell = 1'b1;
        end
        checks++;
        if (!fell) begin errors++; $display("FAIL simul_coin_end: coin end seen=%b expected 1", fell); end
        repeat (10) @(posedge clk_sys);
        #1 sif.req_start2 = 1'b1;
        #1;
        checks++;
        if ({sif.busy, sif.coin_out, sif.start1_out, sif.start2_out} !== 4'b1000) begin
            errors++;
            $display("FAIL simul_in_gap: got %b expected 1000",
                     {sif.busy, sif.coin_out, sif.start1_out, sif.start2_out});
        end
        repeat (3) @(posedge clk_sys);
        #1 sif.req_start2 = 1'b0;
        wait_done(2000, "simul");
    endtask

    task automatic test_held();
        push_seq(1, 1'b0, 4, 8, 4);
        @(posedge clk_sys);
        #1 sif.req_start1 = 1'b1;
        repeat (40 * 64) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if ({sif.busy, sif.coin_out, sif.start1_out, sif.start2_out} !== 4'b1000) begin
            errors++;
            $display("FAIL held_release: got %b expected 1000",
                     {sif.busy, sif.coin_out, sif.start1_out, sif.start2_out});
        end
        checks++;
        if (sb.size() != 1) begin errors++; $display("FAIL held_pending: got %0d segments expected 1", sb.size()); end
        @(posedge clk_sys);
        #1 sif.req_start1 = 1'b0;
        wait_done(100, "held");
        push_seq(1, 1'b0, 4, 8, 4);
        @(posedge clk_sys);
        #1 sif.req_start1 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 sif.req_start1 = 1'b0;
        wait_done(2000, "held_repress");
    endtask

    task automatic test_midreset();
        seg_t s;
        int   n;
        s.pat = 4'b1100; s.len = 4;  sb.push_back(s);
        s.pat = 4'b1000; s.len = 8;  sb.push_back(s);
        s.pat = 4'b1100; s.len = -1; sb.push_back(s);
        @(posedge clk_sys);
        #1 sif.req_start2 = 1'b1;
        n = 0;
        while (n < 2000 && sb.size() > 1) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (sb.size() != 1) begin errors++; $display("FAIL mrst_second_coin: pending %0d expected 1", sb.size()); end
        repeat (70) @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({sif.busy, sif.coin_out, sif.start1_out, sif.start2_out} !== 4'b0000) begin
            errors++;
            $display("FAIL mrst_async_clear: got %b expected 0000",
                     {sif.busy, sif.coin_out, sif.start1_out, sif.start2_out});
        end
        repeat (3) @(posedge clk_sys);
        #7 reset_n = 1'b1;
        repeat (5 * 64) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if ({sif.busy, sif.coin_out, sif.start1_out, sif.start2_out} !== 4'b0000) begin
            errors++;
            $display("FAIL mrst_held_no_start: got %b expected 0000",
                     {sif.busy, sif.coin_out, sif.start1_out, sif.start2_out});
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL mrst_pending: got %0d segments expected 0", sb.size()); end
        @(posedge clk_sys);
        #1 sif.req_start2 = 1'b0;
        repeat (5) @(posedge clk_sys);
        push_seq(2, 1'b1, 4, 8, 4);
        #1 sif.req_start2 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 sif.req_start2 = 1'b0;
        wait_done(3000, "mrst_repress");
    endtask

    task automatic test_min_params();
        mon_sel = 1;
        push_seq(2, 1'b1, 1, 1, 1);
        @(posedge clk_sys);
        #1 sif2.req_start2 = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 sif2.req_start2 = 1'b0;
        wait_done(1000, "minp");
        mon_sel = 0;
    endtask

    initial begin
        test_reset();
        test_p1();
        test_p2_two_coins();
        test_simultaneous();
        test_held();
        test_midreset();
        test_min_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
